mod_mul_pipe: RTL and testbench
===============================

MOD_MUL_PIPE -- requirements
Module: mod_mul_pipe

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operand pair a/b/in_tag is presented.
REQ-004 SHALL have port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-005 SHALL have port a, input, 12, multiplicand (coefficient).
REQ-006 SHALL have port b, input, 12, multiplier (twiddle factor).
REQ-007 SHALL have port in_tag, input, 8, sideband (coefficient address), carried unchanged with its operands.
REQ-008 SHALL have port out_valid, output, 1, res/out_tag hold a valid result.
REQ-009 SHALL have port out_ready, input, 1, downstream add/sub (div-by-2) stage consumes the result.
REQ-010 SHALL have port res, output, 12, (a*b) mod 3329, range [0,3328].
REQ-011 SHALL have port out_tag, output, 8, in_tag of the operand pair that produced res.

Function
REQ-012 SHALL accept an operand pair on a rising edge where in_valid && in_ready ("transfer in").
REQ-013 SHALL present a result on a rising edge where out_valid && out_ready ("transfer out").
REQ-014 SHALL be a 3-stage pipeline (S1: 24-bit product p=a*b; S2: Barrett quotient t=(p*5039)>>24 and t*3329; S3: r=p-t*3329 plus conditional -3329 correction(s)), each stage with its own valid bit.
REQ-015 SHALL produce res exactly equal to (a*b) mod 3329 for every 12-bit a and b, including a or b >= 3329, using as many corrections as needed.
REQ-016 SHALL have latency 3 cycles: a pair transferred in on edge N gives out_valid=1 after edge N+3 when no stall occurs.
REQ-017 SHALL sustain throughput of one pair per cycle while out_ready=1.
REQ-018 SHALL stall globally: stall = out_valid && !out_ready; during stall, all stage registers and valid bits hold.
REQ-019 SHALL drive in_ready = !stall combinationally; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL hold res, out_tag and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when not stalled, load a bubble (valid=0) into S1 if in_valid=0; bubbles advance like data.
REQ-022 SHALL, on simultaneous transfer in and transfer out, perform both in the same cycle without loss or duplication.
REQ-023 SHALL preserve input order: results and tags emerge in acceptance order.
REQ-024 SHALL ignore a, b and in_tag when no transfer in occurs.

Reset
REQ-025 SHALL, while rst=1, clear all stage valid bits, out_valid=0, res=0, out_tag=0, independent of clk.
REQ-026 SHALL drop all in-flight operands when rst asserts mid-operation; none appear after release.
REQ-027 SHALL drive in_ready=1 during and after reset (stall=0 because out_valid=0).
REQ-028 SHALL accept a transfer in on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL support macro MOD_MUL_IN_REG_EN.
REQ-030 SHALL, with MOD_MUL_IN_REG_EN defined, add a registered input stage S0 (a, b, in_tag, valid) ahead of S1, giving latency 4; S0 obeys the same stall rule and resets with REQ-025.
REQ-031 SHALL, without MOD_MUL_IN_REG_EN, feed a/b directly into the S1 multiplier, giving latency 3.
REQ-032 SHALL keep ports, handshake rules, in_ready equation and results identical in both builds; only latency differs.

Verification
REQ-033 SHALL pass: a=3328, b=3328, out_ready=1 -> res=1, out_valid 3 cycles later (4 with MOD_MUL_IN_REG_EN).
REQ-034 SHALL pass: a=4095, b=4095, tag=0x5A -> res=852, out_tag=0x5A; a=2, b=1665 -> res=1; a=0, b=1234 -> res=0.
REQ-035 SHALL pass: 256 back-to-back pairs (a=i, b=17, tag=i), out_ready=1 -> 256 consecutive out_valid cycles, res=(17*i) mod 3329, tags 0..255 in order.
REQ-036 SHALL pass: stream with out_ready=0 for 5 cycles after first out_valid -> in_ready=0 for those cycles, res/out_tag stable, no loss or duplication after out_ready returns to 1.
REQ-037 SHALL pass: rst pulsed while 3 pairs are in flight -> out_valid=0, res=0, out_tag=0 immediately; no stale result after release; next pair tagged 0x11 emerges first.
REQ-038 SHALL pass: random a, b, in_valid and out_ready over 10000 cycles -> results match a reference model of (a*b) mod 3329 in order.

Source files
------------

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier: res = (a*b) mod 3329 via Barrett reduction, valid/ready handshake.
// Optional MOD_MUL_IN_REG_EN adds a registered input stage S0 (latency 4 instead of 3).
module mod_mul_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [7:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] res,
  output logic [7:0]  out_tag
);
  localparam int unsigned Q         = 3329;
  localparam int unsigned BARRETT_M = 5039;   // floor(2^24 / 3329)

  // One global stall freezes every stage, so bubbles and data move in lockstep.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic        m_valid;
  logic [11:0] m_a;
  logic [11:0] m_b;
  logic [7:0]  m_tag;

`ifdef MOD_MUL_IN_REG_EN
  logic        s0_valid;
  logic [11:0] s0_a;
  logic [11:0] s0_b;
  logic [7:0]  s0_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_tag   <= '0;
    end else if (!stall) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_a   <= a;
        s0_b   <= b;
        s0_tag <= in_tag;
      end
    end
  end

  assign m_valid = s0_valid;
  assign m_a     = s0_a;
  assign m_b     = s0_b;
  assign m_tag   = s0_tag;
`else
  assign m_valid = in_valid;
  assign m_a     = a;
  assign m_b     = b;
  assign m_tag   = in_tag;
`endif

  // S1: full 24-bit product
  logic        s1_valid;
  logic [23:0] s1_p;
  logic [7:0]  s1_tag;
  logic [23:0] prod;

  assign prod = 24'(m_a) * 24'(m_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= m_valid;
      if (m_valid) begin
        s1_p   <= prod;
        s1_tag <= m_tag;
      end
    end
  end

  // S2: Barrett quotient estimate; t never exceeds floor(p/Q) and undershoots by at most 1
  logic        s2_valid;
  logic [23:0] s2_p;
  logic [23:0] s2_tq;
  logic [7:0]  s2_tag;
  logic [12:0] t_est;
  logic [23:0] tq;

  assign t_est = 13'((37'(s1_p) * 37'(BARRETT_M)) >> 24);
  assign tq    = 24'(t_est) * 24'(Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_tq    <= '0;
      s2_tag   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p   <= s1_p;
        s2_tq  <= tq;
        s2_tag <= s1_tag;
      end
    end
  end

  // S3 is split: subtract into s3_r, then correct into the output register
  logic        s3_valid;
  logic [13:0] s3_r;
  logic [7:0]  s3_tag;
  logic [13:0] r_raw;

  assign r_raw = 14'(s2_p - s2_tq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_tag   <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_r   <= r_raw;
        s3_tag <= s2_tag;
      end
    end
  end

  // One subtraction suffices for r < 2Q; the second keeps the result safe against any t undershoot of 2.
  logic [13:0] r_fix;

  always_comb begin
    r_fix = s3_r;
    for (int i = 0; i < 2; i++) begin
      if (r_fix >= 14'(Q)) r_fix = r_fix - 14'(Q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        res     <= 12'(r_fix);
        out_tag <= s3_tag;
      end
    end
  end

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Self-checking bench for mod_mul_pipe: queue-based reference model of (a*b) mod 3329 in order.
// Honours MOD_MUL_IN_REG_EN for the expected latency.
module tb_mod_mul_pipe;
`ifdef MOD_MUL_IN_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] res;
  logic [7:0]  out_tag;

  mod_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] r;
    logic [7:0]  t;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic        prev_stall = 1'b0;
  logic [11:0] prev_res   = '0;
  logic [7:0]  prev_tag   = '0;
  logic        last_fire  = 1'b0;
  int          step_cnt   = 0;
  int          fire_cnt   = 0;
  int          first_fire = -1;
  int          last_fire_step = -1;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, obs, obs, expv, expv);
    end
  endtask

  function automatic logic [11:0] ref_mod(input logic [11:0] x, input logic [11:0] y);
    int unsigned p;
    p = 32'(x) * 32'(y);
    return 12'(p % 3329);
  endfunction

  // Drives one cycle of inputs at negedge, checks outputs, and updates the model for the coming edge.
  task automatic step(input logic iv, input logic [11:0] ia, input logic [11:0] ib,
                      input logic [7:0] it, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    in_tag    = it;
    out_ready = ordy;
    #1;
    step_cnt++;
    if (prev_stall) begin
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_res", 32'(res), 32'(prev_res));
      check_val("hold_tag", 32'(out_tag), 32'(prev_tag));
    end
    check_val("in_ready", 32'(in_ready), 32'(!(out_valid && !ordy)));
    last_fire = out_valid && ordy;
    if (last_fire) begin
      fire_cnt++;
      if (first_fire < 0) first_fire = step_cnt;
      last_fire_step = step_cnt;
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("res", 32'(res), 32'(e.r));
        check_val("out_tag", 32'(out_tag), 32'(e.t));
      end
    end
    if (iv && in_ready) begin
      e.r = ref_mod(ia, ib);
      e.t = it;
      exp_q.push_back(e);
    end
    prev_stall = out_valid && !ordy;
    prev_res   = res;
    prev_tag   = out_tag;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 12'($urandom), 12'($urandom), 8'($urandom), ordy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 60) begin
      idle(1'b1);
      n++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int stalled;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    #1 rst = 1'b1;
    #2;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_res", 32'(res), 32'd0);
    check_val("rst_out_tag", 32'(out_tag), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Latency with a = b = 3328 (result 1)
    step(1'b1, 12'd3328, 12'd3328, 8'hA5, 1'b1);
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (!last_fire && n < 20);
    check_val("latency", 32'(n - 1), 32'(LAT));
    drain();

    // Directed corner values
    step(1'b1, 12'd4095, 12'd4095, 8'h5A, 1'b1);
    step(1'b1, 12'd2,    12'd1665, 8'h01, 1'b1);
    step(1'b1, 12'd0,    12'd1234, 8'h02, 1'b1);
    drain();

    // 256 back-to-back pairs
    fire_cnt   = 0;
    first_fire = -1;
    for (int i = 0; i < 256; i++) step(1'b1, 12'(i), 12'd17, 8'(i), 1'b1);
    drain();
    check_val("b2b_count", 32'(fire_cnt), 32'd256);
    check_val("b2b_span", 32'(last_fire_step - first_fire + 1), 32'd256);

    // Backpressure: out_ready low for 5 cycles once a result is presented
    stalled = 0;
    n = 0;
    while (stalled < 5 && n < 30) begin
      step(1'b1, 12'($urandom), 12'($urandom), 8'(8'h40 + n), 1'b0);
      if (out_valid) begin
        check_val("stall_in_ready", 32'(in_ready), 32'd0);
        stalled++;
      end
      n++;
    end
    check_val("stall_cycles", 32'(stalled), 32'd5);
    drain();

    // Reset with pairs in flight
    for (int i = 0; i < 4; i++) step(1'b1, 12'(100 + i), 12'(7 + i), 8'(8'h30 + i), 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_res", 32'(res), 32'd0);
    check_val("mid_rst_out_tag", 32'(out_tag), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    fire_cnt = 0;
    step(1'b1, 12'd1000, 12'd999, 8'h11, 1'b1);
    drain();
    check_val("post_rst_count", 32'(fire_cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 99) < 70), 12'($urandom), 12'($urandom), 8'($urandom),
           1'($urandom_range(0, 99) < 75));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
